// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
// Op codes, FSM states and the iterative-op predicate.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOTHING = 3'b000,
    OP_ADD     = 3'b001,
    OP_SUB     = 3'b010,
    OP_AND     = 3'b011,
    OP_OR      = 3'b100,
    OP_SLT     = 3'b101,
    OP_MUL     = 3'b110,
    OP_DIVU    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_alu_state_e;

  function automatic logic OP_IS_ITER(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// One bit per clock; last flags the final iteration's cycle.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic             active;
  logic [CNT_W-1:0] count;
  alu_op_e          op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign last   = active && (count == CNT_W'(WIDTH - 1));
  assign res_lo = lo_n;
  assign res_hi = hi_n;

  // One MUL or DIVU step from the current partial state
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd : '0)};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (op_q == OP_MUL) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_n = diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand latch and per-clock iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      count  <= '0;
      op_q   <= OP_NOTHING;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (load) begin
      active <= 1'b1;
      count  <= '0;
      op_q   <= op;
      opnd   <= (op == OP_MUL) ? a : b;
      hi_q   <= '0;
      lo_q   <= (op == OP_MUL) ? b : a;
    end else if (active) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      count <= count + 1'b1;
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: registered single-cycle ops plus
// iterative MUL/DIVU behind a start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_zero
);

  seq_alu_state_e   state;
  seq_alu_state_e   state_n;
  alu_op_e          op_in;
  logic [WIDTH-1:0] alu_res;
  logic             is_dz;
  logic             accept;
  logic             load;
  logic             md_last;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  assign op_in  = alu_op_e'(operation);
  assign is_dz  = (op_in == OP_DIVU) && (b == '0);
  assign accept = (state == IDLE) && start;
  assign load   = accept && OP_IS_ITER(op_in) && !is_dz;

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .op     (op_in),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );

  // Single-cycle result; SLT uses a true signed compare
  always_comb begin
    alu_res = '0;
    unique case (op_in)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = load ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (md_last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output registers, held between completions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b1;
      div_zero <= 1'b0;
    end else if (accept && !load) begin
      if (is_dz) begin
        result   <= '1;
        hi       <= a;
        zero     <= 1'b0;
        div_zero <= 1'b1;
      end else begin
        result   <= alu_res;
        hi       <= '0;
        zero     <= (alu_res == '0);
        div_zero <= 1'b0;
      end
    end else if ((state == RUN) && md_last) begin
      result   <= md_lo;
      hi       <= md_hi;
      zero     <= (md_lo == '0);
      div_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
// Hand-computed vectors at WIDTH=32.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        div_zero;

  int n_cmp;
  int n_err;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operation (operation),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit poke,
                        output int lat,
                        output int nbusy);
    start     = 1'b1;
    operation = op;
    a         = x;
    b         = y;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (poke && lat == 5) begin
        start     = 1'b1;
        operation = OP_DIVU;
        a         = 32'd100;
        b         = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) chk("timeout", {63'd0, done}, 64'd1);
  endtask

  int lat;
  int nb;
  int ndone;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    operation = 3'd0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_res", {32'd0, result}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, lat, nb);
    chk("add_res", {32'd0, result}, 64'h8000_0000);
    chk("add_lat", lat, 64'd1);
    chk("add_zero", {63'd0, zero}, 64'd0);
    @(negedge clk);
    chk("add_pulse", {63'd0, done}, 64'd0);

    run_op(OP_SUB, 32'd5, 32'd5, 0, lat, nb);
    chk("sub_res", {32'd0, result}, 64'd0);
    chk("sub_zero", {63'd0, zero}, 64'd1);
    @(negedge clk);

    run_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, lat, nb);
    chk("and_res", {32'd0, result}, 64'h00F0_00F0);
    @(negedge clk);

    run_op(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, lat, nb);
    chk("or_res", {32'd0, result}, 64'hFFF0_FFF0);
    @(negedge clk);

    run_op(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, lat, nb);
    chk("slt0_res", {32'd0, result}, 64'd0);
    chk("slt0_lat", lat, 64'd1);
    @(negedge clk);

    run_op(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 0, lat, nb);
    chk("slt1_res", {32'd0, result}, 64'd1);
    @(negedge clk);

    run_op(OP_NOTHING, 32'h1234, 32'h5678, 0, lat, nb);
    chk("nop_res", {32'd0, result}, 64'd0);
    @(negedge clk);

    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, nb);
    chk("mulmax", {hi, result}, 64'hFFFF_FFFE_0000_0001);
    chk("mul_lat", lat, 64'd33);
    chk("mul_busy", nb, 64'd32);
    chk("mul_zero", {63'd0, zero}, 64'd0);
    @(negedge clk);
    chk("mul_pulse", {63'd0, done}, 64'd0);

    run_op(OP_MUL, 32'd0, 32'h1234, 0, lat, nb);
    chk("mul0", {hi, result}, 64'd0);
    chk("mul0_lat", lat, 64'd33);
    chk("mul0_zero", {63'd0, zero}, 64'd1);
    @(negedge clk);

    run_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, 0, lat, nb);
    chk("mul_mix", {hi, result}, 64'h0000_0002_000B_000F);
    @(negedge clk);

    run_op(OP_DIVU, 32'd100, 32'd7, 0, lat, nb);
    chk("div_q", {32'd0, result}, 64'd14);
    chk("div_r", {32'd0, hi}, 64'd2);
    chk("div_dz", {63'd0, div_zero}, 64'd0);
    chk("div_lat", lat, 64'd33);
    repeat (3) @(negedge clk);
    chk("hold_q", {32'd0, result}, 64'd14);

    run_op(OP_DIVU, 32'd5, 32'd9, 0, lat, nb);
    chk("divlt_q", {32'd0, result}, 64'd0);
    chk("divlt_r", {32'd0, hi}, 64'd5);
    @(negedge clk);

    run_op(OP_DIVU, 32'h1234, 32'd0, 0, lat, nb);
    chk("dz_q", {32'd0, result}, 64'hFFFF_FFFF);
    chk("dz_r", {32'd0, hi}, 64'h1234);
    chk("dz_flag", {63'd0, div_zero}, 64'd1);
    chk("dz_lat", lat, 64'd1);
    @(negedge clk);

    run_op(OP_OR, 32'd1, 32'd2, 0, lat, nb);
    chk("or_hi", {32'd0, hi}, 64'd0);
    chk("or_dzclr", {63'd0, div_zero}, 64'd0);
    @(negedge clk);

    run_op(OP_MUL, 32'd3, 32'd5, 1, lat, nb);
    chk("ign_res", {hi, result}, 64'd15);
    chk("ign_lat", lat, 64'd33);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_once", ndone, 64'd0);
    chk("ign_hold", {32'd0, result}, 64'd15);

    start     = 1'b1;
    operation = OP_MUL;
    a         = 32'hFFFF_FFFF;
    b         = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_res", {32'd0, result}, 64'd0);
    chk("mrst_zero", {63'd0, zero}, 64'd1);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mrst_nodone", ndone, 64'd0);

    run_op(OP_ADD, 32'd2, 32'd3, 0, lat, nb);
    chk("post_add", {32'd0, result}, 64'd5);
    chk("post_lat", lat, 64'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
